// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
//   Packs instruction fields plus a full-width immediate into a 32-bit RV32
//   instruction word (inverse of decode-side immediate extraction). Single
//   registered output slot with valid/ready on both sides. Immediates are
//   range-checked against the selected format; out-of-range values still pack
//   the truncated bits but raise out_err.
//
//   Optional feature macro: ENC_LI_EN
//     defined   : fmt 6 expands the LI pseudo-instruction into ADDI, LUI or
//                 LUI+ADDI (two-word sequence through the LI_LO state).
//     undefined : fmt 6 is treated as reserved (NOP_WORD, out_err=1) and the
//                 control reduces to a single IDLE state.
// -----------------------------------------------------------------------------
module instruction_encoder #(
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last,
   output logic        out_err
);

   localparam logic [2:0] FMT_R  = 3'd0;
   localparam logic [2:0] FMT_I  = 3'd1;
   localparam logic [2:0] FMT_S  = 3'd2;
   localparam logic [2:0] FMT_B  = 3'd3;
   localparam logic [2:0] FMT_U  = 3'd4;
   localparam logic [2:0] FMT_J  = 3'd5;
`ifdef ENC_LI_EN
   localparam logic [2:0] FMT_LI = 3'd6;
`endif

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   // ---------------------------------------------------------------------------
   // Field packing and range checking helpers
   // ---------------------------------------------------------------------------

   // True when every bit of the given upper slice agrees (sign-extension holds).
   function automatic logic all_same(input logic [31:0] v, input int unsigned lsb);
      logic ones;
      logic zeros;
      ones  = 1'b1;
      zeros = 1'b1;
      for (int unsigned b = 0; b < 32; b++) begin
         if (b >= lsb) begin
            ones  = ones  & v[b];
            zeros = zeros & ~v[b];
         end
      end
      return ones | zeros;
   endfunction

   // Pack fields for the real RV32 formats; anything else becomes NOP_WORD.
   function automatic logic [31:0] pack_word(
      input logic [2:0]  fmt,
      input logic [6:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [31:0] imm
   );
      logic [31:0] w;
      case (fmt)
         FMT_R: w = {f7, rs2, rs1, f3, rd, op};
         FMT_I: w = {imm[11:0], rs1, f3, rd, op};
         FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         FMT_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         FMT_U: w = {imm[31:12], rd, op};
         FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: w = NOP_WORD;
      endcase
      return w;
   endfunction

   // Immediate range check per format; reserved formats always flag.
   function automatic logic imm_err(input logic [2:0] fmt, input logic [31:0] imm);
      logic e;
      case (fmt)
         FMT_R:         e = 1'b0;
         FMT_I, FMT_S:  e = !all_same(imm, 11);
         FMT_B:         e = !all_same(imm, 12) || imm[0];
         FMT_J:         e = !all_same(imm, 20) || imm[0];
         FMT_U:         e = |imm[11:0];
         default:       e = 1'b1;
      endcase
      return e;
   endfunction

`ifdef ENC_LI_EN
   // ADDI rd, rs1, lo
   function automatic logic [31:0] addi_word(
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [11:0] lo
   );
      return {lo, rs1, 3'b000, rd, OP_IMM};
   endfunction

   // LUI rd, hi
   function automatic logic [31:0] lui_word(input logic [4:0] rd, input logic [19:0] hi);
      return {hi, rd, OP_LUI};
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // Stage p0: combinational encode of the presented request
   // ---------------------------------------------------------------------------
   logic [31:0] enc_instr_p0;
   logic        enc_err_p0;
   logic        enc_two_p0;   // LI needs a trailing ADDI word
   logic        accept;

`ifdef ENC_LI_EN
   typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;
   state_t      state;
   logic [4:0]  li_rd;
   logic [11:0] li_lo;
   logic [19:0] li_hi_p0;
   logic        li_fits_p0;

   // Upper part rounds up when lo is negative so that LUI+ADDI rebuilds imm;
   // adding imm[11] to imm[31:12] equals (imm + 0x800)[31:12] with wraparound.
   assign li_hi_p0   = in_imm[31:12] + {19'd0, in_imm[11]};
   assign li_fits_p0 = all_same(in_imm, 11);

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
`else
   assign in_ready = !out_valid || out_ready;
`endif

   assign accept = in_valid && in_ready;

   // Select the first word of the request and whether a second word follows.
   always_comb begin
      enc_instr_p0 = pack_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                               in_funct3, in_funct7, in_imm);
      enc_err_p0   = imm_err(in_fmt, in_imm);
      enc_two_p0   = 1'b0;
`ifdef ENC_LI_EN
      if (in_fmt == FMT_LI) begin
         enc_err_p0 = 1'b0;
         if (li_fits_p0) begin
            enc_instr_p0 = addi_word(in_rd, 5'd0, in_imm[11:0]);
         end else begin
            enc_instr_p0 = lui_word(in_rd, li_hi_p0);
            enc_two_p0   = (in_imm[11:0] != 12'd0);
         end
      end
`endif
   end

`ifdef ENC_LI_EN
   // Hold rd/lo of an accepted request for the trailing ADDI of an LI pair.
   always_ff @(posedge clk) begin
      if (accept) begin
         li_rd <= in_rd;
         li_lo <= in_imm[11:0];
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Stage p1: output register and LI sequencing
   // ---------------------------------------------------------------------------
   // Load accepted words, emit the pending ADDI once the LUI is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
`ifdef ENC_LI_EN
         state     <= IDLE;
`endif
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_instr <= enc_instr_p0;
            out_err   <= enc_err_p0;
            out_last  <= !enc_two_p0;
`ifdef ENC_LI_EN
            if (enc_two_p0) begin
               state <= LI_LO;
            end
`endif
         end
`ifdef ENC_LI_EN
         else if ((state == LI_LO) && out_ready) begin
            out_valid <= 1'b1;
            out_instr <= addi_word(li_rd, li_rd, li_lo);
            out_err   <= 1'b0;
            out_last  <= 1'b1;
            state     <= IDLE;
         end
`endif
         else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder
//   Directed vectors with hand-computed expected words for instruction_encoder.
//   LI sequences are exercised when ENC_LI_EN is defined; otherwise fmt 6 is
//   checked as a reserved format.
// -----------------------------------------------------------------------------
module tb_instruction_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        out_err;

   int n_checks = 0;
   int n_pass   = 0;

   instruction_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Present a request and wait (bounded) until it is accepted; returns #1
   // after the accepting edge with in_valid dropped.
   task automatic issue(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      int t;
      in_fmt    = fmt;
      in_opcode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_funct3 = f3;
      in_funct7 = f7;
      in_imm    = imm;
      in_valid  = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("accept_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] instr,
                              input logic err, input logic last);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_instr"}, out_instr, instr);
      check({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
      check({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_fmt    = 3'd0;
      in_opcode = 7'd0;
      in_rd     = 5'd0;
      in_rs1    = 5'd0;
      in_rs2    = 5'd0;
      in_funct3 = 3'd0;
      in_funct7 = 7'd0;
      in_imm    = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      check("rst_last",  {31'd0, out_last}, 32'd0);
      check("rst_err",   {31'd0, out_err}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back single-word formats with the consumer always ready
      issue(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
      expect_word("i_addi", 32'hFFF0_0293, 1'b0, 1'b1);
      issue(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
      expect_word("b_beq8", 32'h0020_8463, 1'b0, 1'b1);
      issue(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
      check("b_odd_err", {31'd0, out_err}, 32'd1);
      issue(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h800);
      check("s_range_err", {31'd0, out_err}, 32'd1);
      issue(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
      expect_word("j_jal", 32'h0010_00EF, 1'b0, 1'b1);
      issue(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
      expect_word("r_sub", 32'h4020_81B3, 1'b0, 1'b1);
      issue(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
      expect_word("u_lui", 32'hABCD_E3B7, 1'b0, 1'b1);
      issue(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0123);
      expect_word("u_lowbits", 32'h0000_03B7, 1'b1, 1'b1);
      issue(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      expect_word("fmt7", 32'h0000_0013, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure on a single word: held stable, no new acceptance
      out_ready = 1'b0;
      issue(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("bp_instr", out_instr, 32'h0010_0293);
         check("bp_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_drain", {31'd0, out_valid}, 32'd0);

`ifdef ENC_LI_EN
      // LI needing LUI+ADDI with the first word stalled for 3 cycles
      out_ready = 1'b0;
      issue(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
      expect_word("li_lui", 32'h1234_6537, 1'b0, 1'b0);
      // a competing request during LI_LO must be ignored
      in_fmt   = 3'd1;
      in_imm   = 32'd7;
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("li_hold_instr", out_instr, 32'h1234_6537);
         check("li_hold_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      expect_word("li_addi", 32'hFFF5_0513, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("li_pair_done", {31'd0, out_valid}, 32'd0);

      issue(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
      expect_word("li_lui_only", 32'h0000_1537, 1'b0, 1'b1);
      issue(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFB);
      expect_word("li_addi_only", 32'hFFB0_0513, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("li_single_done", {31'd0, out_valid}, 32'd0);

      // Async reset while in LI_LO drops the pending ADDI
      out_ready = 1'b0;
      issue(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
      check("li_rst_pre", {31'd0, out_last}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("li_rst_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("li_rst_ready", {31'd0, in_ready}, 32'd1);
      check("li_rst_novalid", {31'd0, out_valid}, 32'd0);
      issue(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
      expect_word("post_rst", 32'hFFF0_0293, 1'b0, 1'b1);
`else
      // Without LI support fmt 6 is reserved
      issue(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
      expect_word("fmt6_nop", 32'h0000_0013, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("fmt6_single", {31'd0, out_valid}, 32'd0);
`endif

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
